// File: rtl/enemy_pool.sv
// Obstacle table for the runner: moves live enemies left each frame, retires off-screen ones, allocates via req/ack.
// Optional internal LFSR-driven spawner is enabled with `define ENEMY_AUTOSPAWN_EN.
module enemy_pool #(
    parameter int SLOTS    = 8,
    parameter int XW       = 10,
    parameter int YW       = 9,
    parameter int SW       = 4,
    parameter int SCREEN_W = 640,
    parameter int GROUND_Y = 400,
    parameter int AIR_Y    = 340
) (
    input  logic                  clk3,
    input  logic                  rst_n,
    input  logic                  frame_tick,
    input  logic                  freeze,
    input  logic [SW-1:0]         speed,
    input  logic                  spawn_req,
    input  logic [1:0]            spawn_kind,
    output logic                  spawn_ack,
    output logic [SLOTS-1:0]      slot_valid,
    output logic [SLOTS*XW-1:0]   slot_x,
    output logic [SLOTS*YW-1:0]   slot_y,
    output logic [SLOTS*2-1:0]    slot_kind,
    output logic [4:0]            active_count,
    output logic                  passed,
    output logic [4:0]            passed_num
);

    function automatic logic [4:0] popcount(input logic [SLOTS-1:0] v);
        logic [4:0] c;
        c = 5'd0;
        for (int k = 0; k < SLOTS; k++) begin
            c = c + {4'd0, v[k]};
        end
        return c;
    endfunction

    logic [SLOTS-1:0] valid_q, valid_d;
    logic [XW-1:0]    x_q    [SLOTS];
    logic [XW-1:0]    x_d    [SLOTS];
    logic [YW-1:0]    y_q    [SLOTS];
    logic [YW-1:0]    y_d    [SLOTS];
    logic [1:0]       kind_q [SLOTS];
    logic [1:0]       kind_d [SLOTS];
    logic             ack_q, ack_d;
    logic             passed_q, passed_d;
    logic [4:0]       passed_num_q, passed_num_d;
    logic [4:0]       active_q, active_d;

    logic [SLOTS-1:0] free_oh_s;
    logic             alloc_s;
    logic             alloc_ext_s;
    logic [1:0]       alloc_kind_s;
    logic [1:0]       kind_norm_s;
    logic [YW-1:0]    alloc_y_s;
    logic [4:0]       retire_cnt_s;
    logic             move_s;

    // Lowest invalid slot as a one-hot mask (isolate lowest zero bit)
    assign free_oh_s = ~valid_q & (valid_q + {{(SLOTS-1){1'b0}}, 1'b1});
    assign move_s    = frame_tick & ~freeze & (speed != {SW{1'b0}});

`ifdef ENEMY_AUTOSPAWN_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic [5:0]  gap_q, gap_d;
    logic        int_req_s;
    logic        int_alloc_s;

    assign int_req_s   = (gap_q == 6'd0);
    assign alloc_ext_s = spawn_req & ~ack_q & ~freeze & (|free_oh_s);
    assign int_alloc_s = int_req_s & ~spawn_req & ~ack_q & ~freeze & (|free_oh_s);
    assign alloc_s     = alloc_ext_s | int_alloc_s;
    assign alloc_kind_s = alloc_ext_s ? spawn_kind : lfsr_q[6:5];

    // LFSR stepping and inter-spawn gap countdown
    always_comb begin
        lfsr_d = lfsr_q;
        gap_d  = gap_q;
        if (!freeze && frame_tick) begin
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end else begin
            lfsr_d = lfsr_q;
        end
        if (int_alloc_s) begin
            gap_d = 6'd24 + {1'b0, lfsr_q[4:0]};
        end else if (!freeze && frame_tick && gap_q != 6'd0) begin
            gap_d = gap_q - 6'd1;
        end else begin
            gap_d = gap_q;
        end
    end

    // Autospawn state registers; first gap derived from the seed
    always_ff @(posedge clk3) begin
        if (!rst_n) begin
            lfsr_q <= 16'hACE1;
            gap_q  <= 6'd25;
        end else begin
            lfsr_q <= lfsr_d;
            gap_q  <= gap_d;
        end
    end
`else
    assign alloc_ext_s  = spawn_req & ~ack_q & ~freeze & (|free_oh_s);
    assign alloc_s      = alloc_ext_s;
    assign alloc_kind_s = spawn_kind;
`endif

    assign kind_norm_s = (alloc_kind_s == 2'd3) ? 2'd0 : alloc_kind_s;
    assign alloc_y_s   = (kind_norm_s == 2'd2) ? YW'(AIR_Y) : YW'(GROUND_Y);

    // Slot motion, retirement and allocation next-state
    always_comb begin
        valid_d      = valid_q;
        x_d          = x_q;
        y_d          = y_q;
        kind_d       = kind_q;
        retire_cnt_s = 5'd0;
        for (int i = 0; i < SLOTS; i++) begin
            if (move_s && valid_q[i]) begin
                if (x_q[i] <= XW'(speed)) begin
                    valid_d[i]   = 1'b0;
                    x_d[i]       = {XW{1'b0}};
                    retire_cnt_s = retire_cnt_s + 5'd1;
                end else begin
                    x_d[i] = x_q[i] - XW'(speed);
                end
            end else if (alloc_s && free_oh_s[i]) begin
                valid_d[i] = 1'b1;
                x_d[i]     = XW'(SCREEN_W);
                y_d[i]     = alloc_y_s;
                kind_d[i]  = kind_norm_s;
            end else begin
                valid_d[i] = valid_q[i];
            end
        end
        ack_d        = alloc_ext_s;
        passed_d     = (retire_cnt_s != 5'd0);
        passed_num_d = retire_cnt_s;
        active_d     = popcount(valid_d);
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk3) begin
        if (!rst_n) begin
            valid_q      <= {SLOTS{1'b0}};
            ack_q        <= 1'b0;
            passed_q     <= 1'b0;
            passed_num_q <= 5'd0;
            active_q     <= 5'd0;
            for (int i = 0; i < SLOTS; i++) begin
                x_q[i]    <= {XW{1'b0}};
                y_q[i]    <= {YW{1'b0}};
                kind_q[i] <= 2'd0;
            end
        end else begin
            valid_q      <= valid_d;
            ack_q        <= ack_d;
            passed_q     <= passed_d;
            passed_num_q <= passed_num_d;
            active_q     <= active_d;
            for (int i = 0; i < SLOTS; i++) begin
                x_q[i]    <= x_d[i];
                y_q[i]    <= y_d[i];
                kind_q[i] <= kind_d[i];
            end
        end
    end

    for (genvar g = 0; g < SLOTS; g++) begin : g_pack
        assign slot_x[g*XW +: XW]  = x_q[g];
        assign slot_y[g*YW +: YW]  = y_q[g];
        assign slot_kind[g*2 +: 2] = kind_q[g];
    end

    assign slot_valid   = valid_q;
    assign spawn_ack    = ack_q;
    assign passed       = passed_q;
    assign passed_num   = passed_num_q;
    assign active_count = active_q;

endmodule

// File: tb/tb_enemy_pool.sv
// Directed bench for enemy_pool (default build): spawn, motion, retirement, full table, freeze, reset.
module tb_enemy_pool;

    logic        clk3 = 1'b0;
    logic        rst_n;
    logic        frame_tick;
    logic        freeze;
    logic [3:0]  speed;
    logic        spawn_req;
    logic [1:0]  spawn_kind;
    logic        spawn_ack;
    logic [7:0]  slot_valid;
    logic [79:0] slot_x;
    logic [71:0] slot_y;
    logic [15:0] slot_kind;
    logic [4:0]  active_count;
    logic        passed;
    logic [4:0]  passed_num;

    int n_checks = 0;
    int n_fail   = 0;

    enemy_pool dut (
        .clk3(clk3), .rst_n(rst_n), .frame_tick(frame_tick), .freeze(freeze),
        .speed(speed), .spawn_req(spawn_req), .spawn_kind(spawn_kind),
        .spawn_ack(spawn_ack), .slot_valid(slot_valid), .slot_x(slot_x),
        .slot_y(slot_y), .slot_kind(slot_kind), .active_count(active_count),
        .passed(passed), .passed_num(passed_num)
    );

    always #5 clk3 = ~clk3;

    function automatic logic [9:0] x_of(int i);
        return slot_x[i*10 +: 10];
    endfunction
    function automatic logic [8:0] y_of(int i);
        return slot_y[i*9 +: 9];
    endfunction
    function automatic logic [1:0] k_of(int i);
        return slot_kind[i*2 +: 2];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk3);
        #1;
    endtask

    task automatic tick(input logic [3:0] spd);
        frame_tick = 1'b1;
        speed      = spd;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n, input logic [3:0] spd);
        for (int t = 0; t < n; t++) tick(spd);
    endtask

    task automatic spawn(input logic [1:0] k);
        spawn_req  = 1'b1;
        spawn_kind = k;
        step();
        spawn_req  = 1'b0;
        step();
    endtask

    initial begin
        rst_n = 1'b0; frame_tick = 1'b0; freeze = 1'b0; speed = 4'd0;
        spawn_req = 1'b0; spawn_kind = 2'd0;
        step(); step();
        check("rst_valid", slot_valid, 8'h00);
        check("rst_ack", spawn_ack, 1'b0);
        check("rst_passed", passed, 1'b0);
        check("rst_pnum", passed_num, 5'd0);
        check("rst_active", active_count, 5'd0);
        check("rst_x", slot_x, 80'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            frame_tick = (i % 2 == 0);
            speed = 4'd5;
            step();
            check("idle_valid", slot_valid, 8'h00);
            check("idle_passed", passed, 1'b0);
            check("idle_ack", spawn_ack, 1'b0);
        end
        frame_tick = 1'b0;

        // Bird spawn; request held through the ack cycle must not allocate twice
        spawn_req = 1'b1; spawn_kind = 2'd2;
        step();
        check("sp_ack", spawn_ack, 1'b1);
        check("sp_valid", slot_valid, 8'h01);
        check("sp_x", x_of(0), 10'd640);
        check("sp_y", y_of(0), 9'd340);
        check("sp_kind", k_of(0), 2'd2);
        check("sp_active", active_count, 5'd1);
        step();
        check("sp_ack_drop", spawn_ack, 1'b0);
        check("sp_no_dup", active_count, 5'd1);
        spawn_req = 1'b0;

        ticks(3, 4'd5);
        check("mv_x625", x_of(0), 10'd625);
        ticks(41, 4'd15);
        tick(4'd6);
        check("mv_x4", x_of(0), 10'd4);
        check("mv_nopass", passed, 1'b0);
        tick(4'd5);
        check("ret1_valid", slot_valid, 8'h00);
        check("ret1_x", x_of(0), 10'd0);
        check("ret1_passed", passed, 1'b1);
        check("ret1_pnum", passed_num, 5'd1);
        check("ret1_active", active_count, 5'd0);
        step();
        check("ret1_pulse", passed, 1'b0);
        check("ret1_pnum0", passed_num, 5'd0);

        spawn(2'd0);
        spawn(2'd1);
        check("two_valid", slot_valid, 8'h03);
        check("two_y0", y_of(0), 9'd400);
        check("two_y1", y_of(1), 9'd400);
        check("two_k1", k_of(1), 2'd1);
        ticks(42, 4'd15);
        check("two_x1", x_of(1), 10'd10);
        tick(4'd10);
        check("ret2_pnum", passed_num, 5'd2);
        check("ret2_valid", slot_valid, 8'h00);

        // Make slot 3 the oldest survivor, then fill the table
        spawn(2'd0); spawn(2'd1); spawn(2'd0);
        ticks(41, 4'd15);
        check("fill_x0", x_of(0), 10'd25);
        spawn(2'd2);
        check("fill_s3_y", y_of(3), 9'd340);
        tick(4'd15);
        tick(4'd10);
        check("ret3_pnum", passed_num, 5'd3);
        check("ret3_valid", slot_valid, 8'h08);
        check("ret3_x3", x_of(3), 10'd615);
        for (int i = 0; i < 7; i++) spawn(2'd0);
        check("full_valid", slot_valid, 8'hFF);
        check("full_active", active_count, 5'd8);

        spawn_req = 1'b1; spawn_kind = 2'd1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("full_noack", spawn_ack, 1'b0);
        end
        for (int i = 0; i < 40; i++) begin
            tick(4'd15);
            check("full_wait_noack", spawn_ack, 1'b0);
        end
        check("full_x3", x_of(3), 10'd15);
        check("full_x0", x_of(0), 10'd40);
        tick(4'd15);
        check("free3_valid", slot_valid, 8'hF7);
        check("free3_pnum", passed_num, 5'd1);
        check("free3_noack", spawn_ack, 1'b0);
        check("free3_x0", x_of(0), 10'd25);
        step();
        check("reuse_ack", spawn_ack, 1'b1);
        check("reuse_valid", slot_valid, 8'hFF);
        check("reuse_x3", x_of(3), 10'd640);
        check("reuse_k3", k_of(3), 2'd1);
        check("reuse_y3", y_of(3), 9'd400);
        spawn_req = 1'b0;
        step();

        tick(4'd15);
        tick(4'd10);
        check("ret7_pnum", passed_num, 5'd7);
        check("ret7_valid", slot_valid, 8'h08);
        check("ret7_active", active_count, 5'd1);

        freeze = 1'b1; spawn_req = 1'b1; spawn_kind = 2'd2;
        frame_tick = 1'b1; speed = 4'd5;
        for (int i = 0; i < 20; i++) begin
            step();
            check("frz_ack", spawn_ack, 1'b0);
            check("frz_passed", passed, 1'b0);
            check("frz_valid", slot_valid, 8'h08);
            check("frz_x3", x_of(3), 10'd615);
        end
        freeze = 1'b0; frame_tick = 1'b0;
        step();
        check("unfrz_ack", spawn_ack, 1'b1);
        check("unfrz_valid", slot_valid, 8'h09);
        check("unfrz_x0", x_of(0), 10'd640);
        check("unfrz_active", active_count, 5'd2);
        spawn_req = 1'b0;
        step();

        spawn_req = 1'b1; spawn_kind = 2'd0;
        step();
        check("mid_ack", spawn_ack, 1'b1);
        check("mid_valid", slot_valid, 8'h0B);
        rst_n = 1'b0;
        step();
        check("mid_rst_ack", spawn_ack, 1'b0);
        check("mid_rst_valid", slot_valid, 8'h00);
        check("mid_rst_active", active_count, 5'd0);
        rst_n = 1'b1; spawn_kind = 2'd3;
        step();
        check("k3_ack", spawn_ack, 1'b1);
        check("k3_kind", k_of(0), 2'd0);
        check("k3_y", y_of(0), 9'd400);
        spawn_req = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
